// File: rtl/sonyimx_sync_encoder.sv
// -----------------------------------------------------------------------------
// sonyimx_sync_encoder
//
// Purpose:
//   Turns the parallel sensor-model pixel stream (fval/lval plus a
//   DATA_WIDTH*CHANNEL_NUM pixel bus) into a Sony IMX style sync-coded stream
//   for the serializer. Every line gets a 4-word SAV code before its first
//   pixel and a 4-word EAV code after its last pixel, identically on every
//   lane. fval, lval and pixels have a fixed 4-cycle latency.
//
// Parameters:
//   DATA_WIDTH  - bits per pixel word (10 or 12)
//   CHANNEL_NUM - number of parallel lanes, one word per lane per cycle
//
// Ports:
//   clk         - parallel pixel clock (clk_para domain)
//   reset       - asynchronous, active-high; clears all state
//   i_fval      - frame valid from the sensor model
//   i_lval      - line valid from the sensor model
//   iv_pix_data - pixel words, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_fval      - i_fval delayed 4 cycles
//   o_lval      - line valid delayed 4 cycles (invalid lines gated, see below)
//   ov_pix_data - coded stream: pixels, sync words or blanking (0)
//   o_sync_err  - registered 1-cycle pulse on an SAV/EAV collision or on an
//                 lval rising edge that arrives during SAV/ACTIVE
//
// Build option:
//   SONYIMX_INVALID_LINE_EN - when defined, lval pulses with i_fval=0 are
//   encoded with the invalid-line codes (V=1). When undefined, such pulses are
//   dropped at the input: no SAV/EAV, o_lval stays 0 and the data stays 0.
// -----------------------------------------------------------------------------
module sonyimx_sync_encoder #(
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNEL_NUM = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                              o_sync_err
);

  localparam int BUS_W = DATA_WIDTH * CHANNEL_NUM;
  localparam int DEPTH = 4;

  localparam logic [9:0] CODE_SAV_VALID   = 10'h200;
  localparam logic [9:0] CODE_EAV_VALID   = 10'h274;
  localparam logic [9:0] CODE_SAV_INVALID = 10'h2AC;
  localparam logic [9:0] CODE_EAV_INVALID = 10'h2D8;

  typedef enum logic [1:0] {IDLE, SAV, ACTIVE, EAV} state_t;

  // Line valid as seen by the encoder. Without invalid-line support, lval
  // pulses outside the frame are removed here so that the rest of the
  // datapath never sees them.
  logic lval_in;
`ifdef SONYIMX_INVALID_LINE_EN
  assign lval_in = i_lval;
`else
  assign lval_in = i_lval & i_fval;
`endif

  // Delay lines. Index 0 is d1, index DEPTH-1 is d4. The lval line carries
  // one extra stage holding d4 from the previous cycle for falling-edge
  // detection.
  logic [DEPTH-1:0]            fval_pipe_reg;
  logic [DEPTH:0]              lval_pipe_reg;
  logic [DEPTH-1:0][BUS_W-1:0] pix_pipe_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fval_pipe_reg <= '0;
      lval_pipe_reg <= '0;
      pix_pipe_reg  <= '0;
    end else begin
      fval_pipe_reg <= {fval_pipe_reg[DEPTH-2:0], i_fval};
      lval_pipe_reg <= {lval_pipe_reg[DEPTH-1:0], lval_in};
      pix_pipe_reg  <= {pix_pipe_reg[DEPTH-2:0], iv_pix_data};
    end
  end

  assign o_fval = fval_pipe_reg[DEPTH-1];
  assign o_lval = lval_pipe_reg[DEPTH-1];

  logic lval_rise;
  logic lval_d4_fall;
  assign lval_rise    = lval_in & ~lval_pipe_reg[0];
  assign lval_d4_fall = ~lval_pipe_reg[DEPTH-1] & lval_pipe_reg[DEPTH];

  // FSM state. state_reg/wc_reg name the sync word emitted in the previous
  // cycle; the word emitted now is described by state_next/wc_next.
  state_t     state_reg, state_next;
  logic [1:0] wc_reg, wc_next;
  logic       v_reg, v_next;
  logic       sync_err_reg, sync_err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      wc_reg       <= 2'd0;
      v_reg        <= 1'b0;
      sync_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wc_reg       <= wc_next;
      v_reg        <= v_next;
      sync_err_reg <= sync_err_next;
    end
  end

  assign o_sync_err = sync_err_reg;

  always_comb begin
    state_next    = state_reg;
    wc_next       = wc_reg;
    v_next        = v_reg;
    sync_err_next = 1'b0;
    if (reset) begin
      // Keeps the combinational output mux at blanking while reset is held.
      state_next = IDLE;
      wc_next    = 2'd0;
      v_next     = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (lval_rise) begin
            state_next = SAV;
            wc_next    = 2'd0;
            v_next     = ~i_fval;
          end
        end
        SAV: begin
          // A new line start here is illegal input: flag it, keep going.
          sync_err_next = lval_rise;
          if (wc_reg == 2'd3) begin
            state_next = ACTIVE;
            wc_next    = 2'd0;
          end else begin
            wc_next = wc_reg + 2'd1;
          end
        end
        ACTIVE: begin
          sync_err_next = lval_rise;
          if (lval_d4_fall) begin
            state_next = EAV;
            wc_next    = 2'd0;
          end
        end
        EAV: begin
          if (lval_rise) begin
            // Rise during the last EAV word is a normal back-to-back line;
            // any earlier rise cuts the EAV short.
            state_next    = SAV;
            wc_next       = 2'd0;
            v_next        = ~i_fval;
            sync_err_next = (wc_reg != 2'd3);
          end else if (wc_reg == 2'd3) begin
            state_next = IDLE;
            wc_next    = 2'd0;
          end else begin
            wc_next = wc_reg + 2'd1;
          end
        end
        default: begin
          state_next = IDLE;
          wc_next    = 2'd0;
        end
      endcase
    end
  end

  // Output words are selected from the next state rather than a registered
  // copy: with a 4-cycle pixel latency, SAV word 0 has to leave in the same
  // cycle that the lval rising edge arrives at the input.
  logic [9:0]            code10;
  logic [DATA_WIDTH-1:0] xy_word;
  logic [DATA_WIDTH-1:0] sync_word;
  logic                  emit_sync;
  logic                  emit_pix;

  always_comb begin
    code10 = CODE_SAV_VALID;
    if (state_next == EAV) begin
      code10 = v_next ? CODE_EAV_INVALID : CODE_EAV_VALID;
    end else begin
      code10 = v_next ? CODE_SAV_INVALID : CODE_SAV_VALID;
    end
  end

  // The 10-bit codes are left-aligned in wider words.
  assign xy_word = DATA_WIDTH'(code10) << (DATA_WIDTH - 10);

  always_comb begin
    sync_word = '0;
    unique case (wc_next)
      2'd0:    sync_word = '1;
      2'd3:    sync_word = xy_word;
      default: sync_word = '0;
    endcase
  end

  assign emit_sync = (state_next == SAV) || (state_next == EAV);
  assign emit_pix  = (state_next == ACTIVE) && lval_pipe_reg[DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_lane
      assign ov_pix_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        emit_sync ? sync_word :
        emit_pix  ? pix_pipe_reg[DEPTH-1][gi*DATA_WIDTH +: DATA_WIDTH] :
                    '0;
    end
  endgenerate

endmodule

// File: tb/tb_sonyimx_sync_encoder.sv
// -----------------------------------------------------------------------------
// tb_sonyimx_sync_encoder
//
// Drives a 12-bit and a 10-bit instance with the same line stimulus. Each
// directed segment is planned as a per-cycle table: the input pattern and the
// expected output (built from the line-level SAV / pixels / EAV description)
// are written into the plan, the expectations are pushed to a scoreboard and
// popped as each cycle's output is sampled.
// -----------------------------------------------------------------------------
module tb_sonyimx_sync_encoder;

  localparam int PLAN_N = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fval, i_lval;
  logic [47:0] pix12;
  logic [39:0] pix10;
  logic        fval12, lval12, err12;
  logic        fval10, lval10, err10;
  logic [47:0] data12;
  logic [39:0] data10;

  always #5 clk = ~clk;

  sonyimx_sync_encoder #(.DATA_WIDTH(12), .CHANNEL_NUM(4)) u_dut12 (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(pix12), .o_fval(fval12), .o_lval(lval12),
    .ov_pix_data(data12), .o_sync_err(err12)
  );

  sonyimx_sync_encoder #(.DATA_WIDTH(10), .CHANNEL_NUM(4)) u_dut10 (
    .clk(clk), .reset(reset), .i_fval(i_fval), .i_lval(i_lval),
    .iv_pix_data(pix10), .o_fval(fval10), .o_lval(lval10),
    .ov_pix_data(data10), .o_sync_err(err10)
  );

  // kind: 0 blank, 1 all-ones, 2 zero word, 3 XY code, 4 pixel
  typedef struct {
    int         kind;
    logic [9:0] code;
    logic [11:0] pv;
    bit         err;
  } exp_t;

  exp_t sb[$];
  bit   hist_f[$];
  bit   hist_l[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lval_cnt;
  int err_cnt;
  int last_e;

  int          plan_kind [PLAN_N];
  logic [9:0]  plan_code [PLAN_N];
  logic [11:0] plan_pv   [PLAN_N];
  bit          plan_err  [PLAN_N];
  bit          plan_f    [PLAN_N];
  bit          plan_l    [PLAN_N];
  logic [11:0] plan_in   [PLAN_N];

  // Expected bus for a given word width: four lanes of the same kind; pixel
  // lanes carry pv+lane so lanes are distinguishable.
  function automatic logic [47:0] exp_bus(int w, int kind, logic [9:0] code, logic [11:0] pv);
    logic [47:0] r;
    logic [11:0] word;
    logic [11:0] m;
    r = '0;
    m = 12'((1 << w) - 1);
    for (int k = 0; k < 4; k++) begin
      case (kind)
        1:       word = m;
        3:       word = 12'(code) << (w - 10);
        4:       word = (pv + 12'(k)) & m;
        default: word = '0;
      endcase
      r = r | (48'(word) << (k * w));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hist_clear();
    hist_f.delete();
    hist_l.delete();
    repeat (4) begin
      hist_f.push_back(1'b0);
      hist_l.push_back(1'b0);
    end
  endtask

  task automatic seg_clear(input bit fv);
    for (int c = 0; c < PLAN_N; c++) begin
      plan_kind[c] = 0;
      plan_code[c] = '0;
      plan_pv[c]   = '0;
      plan_err[c]  = 1'b0;
      plan_f[c]    = fv;
      plan_l[c]    = 1'b0;
      plan_in[c]   = 12'h5A0 + 12'(c);
    end
    last_e = -100;
  endtask

  // Adds one line of length len starting at cycle r. Later lines overwrite
  // whatever an earlier line's EAV would have put in the same cycles.
  task automatic add_line(input int r, input int len, input logic [11:0] base);
    bit fv;
    bit coded;
    bit v;
    int e;
    fv = plan_f[r];
`ifdef SONYIMX_INVALID_LINE_EN
    coded = 1'b1;
`else
    coded = fv;
`endif
    for (int p = 0; p < len; p++) begin
      plan_l[r+p]  = 1'b1;
      plan_in[r+p] = base + 12'(p);
    end
    if (coded) begin
      v = ~fv;
      e = r + 4 + len;
      if (r > last_e && r <= last_e + 3) plan_err[r+1] = 1'b1;
      for (int w = 0; w < 4; w++) begin
        plan_kind[r+w] = (w == 0) ? 1 : (w == 3) ? 3 : 2;
        plan_code[r+w] = v ? 10'h2AC : 10'h200;
      end
      for (int p = 0; p < len; p++) begin
        plan_kind[r+4+p] = 4;
        plan_pv[r+4+p]   = base + 12'(p);
      end
      for (int w = 0; w < 4; w++) begin
        if (e + w < PLAN_N) begin
          plan_kind[e+w] = (w == 0) ? 1 : (w == 3) ? 3 : 2;
          plan_code[e+w] = v ? 10'h2D8 : 10'h274;
        end
      end
      last_e = e;
    end
  endtask

  task automatic step(input bit f, input bit l, input logic [11:0] pv);
    exp_t e;
    bit   gl;
    bit   ef, el;
    @(posedge clk);
    #1;
    i_fval = f;
    i_lval = l;
    pix12  = exp_bus(12, 4, 10'h0, pv);
    pix10  = 40'(exp_bus(10, 4, 10'h0, pv));
`ifdef SONYIMX_INVALID_LINE_EN
    gl = l;
`else
    gl = l & f;
`endif
    hist_f.push_back(f);
    hist_l.push_back(gl);
    ef = hist_f.pop_front();
    el = hist_l.pop_front();
    @(negedge clk);
    chk($sformatf("sb_avail@%0d", cyc), 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("data12@%0d", cyc), 64'(data12), 64'(exp_bus(12, e.kind, e.code, e.pv)));
      chk($sformatf("data10@%0d", cyc), 64'(data10), 64'(exp_bus(10, e.kind, e.code, e.pv)));
      chk($sformatf("err12@%0d", cyc), 64'(err12), 64'(e.err));
      chk($sformatf("err10@%0d", cyc), 64'(err10), 64'(e.err));
    end
    chk($sformatf("lval12@%0d", cyc), 64'(lval12), 64'(el));
    chk($sformatf("lval10@%0d", cyc), 64'(lval10), 64'(el));
    chk($sformatf("fval12@%0d", cyc), 64'(fval12), 64'(ef));
    chk($sformatf("fval10@%0d", cyc), 64'(fval10), 64'(ef));
    if (lval12) lval_cnt++;
    if (err12) err_cnt++;
    cyc++;
  endtask

  task automatic seg_run(input int n);
    exp_t e;
    lval_cnt = 0;
    err_cnt  = 0;
    for (int c = 0; c < n; c++) begin
      e.kind = plan_kind[c];
      e.code = plan_code[c];
      e.pv   = plan_pv[c];
      e.err  = plan_err[c];
      sb.push_back(e);
    end
    for (int c = 0; c < n; c++) step(plan_f[c], plan_l[c], plan_in[c]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data12"}, 64'(data12), 64'(0));
    chk({tag, "_data10"}, 64'(data10), 64'(0));
    chk({tag, "_lval12"}, 64'(lval12), 64'(0));
    chk({tag, "_fval12"}, 64'(fval12), 64'(0));
    chk({tag, "_err12"},  64'(err12),  64'(0));
    chk({tag, "_lval10"}, 64'(lval10), 64'(0));
    chk({tag, "_fval10"}, 64'(fval10), 64'(0));
    chk({tag, "_err10"},  64'(err10),  64'(0));
  endtask

  initial begin
    reset  = 1'b1;
    i_fval = 1'b0;
    i_lval = 1'b0;
    pix12  = '0;
    pix10  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist_clear();

    // One valid 16-pixel line, hide 20.
    seg_clear(1'b1);
    add_line(2, 16, 12'h123);
    seg_run(38);
    chk("line16_lval_cycles", 64'(lval_cnt), 64'(16));

    // Line hide of 5: truncated EAV, full SAV, single error pulse.
    seg_clear(1'b1);
    add_line(2, 6, 12'h300);
    add_line(13, 6, 12'h400);
    seg_run(31);
    chk("collision_err_pulses", 64'(err_cnt), 64'(1));

    // 1-pixel line followed by a line at the minimum hide of 8.
    seg_clear(1'b1);
    add_line(2, 1, 12'h7E1);
    add_line(11, 2, 12'h050);
    seg_run(23);
    chk("hide8_err_pulses", 64'(err_cnt), 64'(0));

    // lval pulse outside the frame.
    seg_clear(1'b0);
    add_line(2, 4, 12'h2C0);
    seg_run(20);
`ifdef SONYIMX_INVALID_LINE_EN
    chk("invalid_lval_cycles", 64'(lval_cnt), 64'(4));
`else
    chk("invalid_lval_cycles", 64'(lval_cnt), 64'(0));
`endif

    // Reset while the 3rd pixel of a line is on the output.
    seg_clear(1'b1);
    add_line(2, 8, 12'h611);
    seg_run(9);
    chk("pre_reset_lval12", 64'(lval12), 64'(1));
    reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    i_lval = 1'b0;
    i_fval = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist_clear();
    chk("sb_empty_after_reset", 64'(sb.size()), 64'(0));

    // Clean line after reset release.
    seg_clear(1'b1);
    add_line(3, 5, 12'h0AA);
    seg_run(18);
    chk("post_reset_lval_cycles", 64'(lval_cnt), 64'(5));
    chk("sb_empty_end", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
